// File: rtl/shake_pkg.sv
// Shared SHAKE types and constants: modes, rates, padding bytes and loader states.
package shake_pkg;

   typedef enum logic {SHAKE128 = 1'b0, SHAKE256 = 1'b1} mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      PAD  = 2'd2,
      HOLD = 2'd3
   } state_t;

   localparam int RATE128_BYTES = 168;
   localparam int RATE256_BYTES = 136;

   localparam logic [7:0] DOMAIN_PAD = 8'h1F;
   localparam logic [7:0] FINAL_PAD  = 8'h80;

   function automatic int rate_of(input mode_t m);
      return (m == SHAKE256) ? RATE256_BYTES : RATE128_BYTES;
   endfunction

endpackage

// File: rtl/shake_word_mask.sv
// Keeps the first taken_i bytes of a message word, zeroes the rest and optionally
// places the SHAKE domain byte directly after the last kept byte.
module shake_word_mask
   import shake_pkg::*;
#(
   parameter int WORD_W = 64,
   parameter int TK_W   = $clog2(WORD_W / 8) + 1
) (
   input  logic [WORD_W-1:0] word_i,
   input  logic [TK_W-1:0]   taken_i,
   input  logic              pad_i,
   output logic [WORD_W-1:0] word_o
);

   localparam int BPW = WORD_W / 8;

   // Per-byte select between message data, domain pad and zero
   always_comb begin
      word_o = '0;
      for (int b = 0; b < BPW; b++) begin
         if (b < int'(taken_i)) begin
            word_o[8*b +: 8] = word_i[8*b +: 8];
         end else if (pad_i && (b == int'(taken_i))) begin
            word_o[8*b +: 8] = DOMAIN_PAD;
         end else begin
            word_o[8*b +: 8] = 8'h00;
         end
      end
   end

endmodule

// File: rtl/shake_block_loader.sv
// Packs a length-prefixed word stream into padded SHAKE128/SHAKE256 rate blocks
// and presents each block to the absorb stage over a valid/ready handshake.
module shake_block_loader
   import shake_pkg::*;
#(
   parameter int WORD_W         = 64,
   parameter int LEN_W          = 32,
   parameter int MAX_RATE_BYTES = 168
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [WORD_W-1:0]           in_data,
   output logic                        blk_valid,
   input  logic                        blk_ready,
   output logic [MAX_RATE_BYTES*8-1:0] blk_data,
   output logic                        blk_last,
   output logic                        blk_mode,
   output logic                        busy
);

   localparam int BPW       = WORD_W / 8;
   localparam int TK_W      = $clog2(BPW) + 1;
   localparam int MAX_WORDS = MAX_RATE_BYTES / BPW;
   localparam int WIDX_W    = $clog2(MAX_WORDS) + 1;
   localparam int POS_W     = $clog2(MAX_RATE_BYTES);

   if (WORD_W < LEN_W + 1) begin : g_chk_hdr
      $error("shake_block_loader: header (LEN_W+1 bits) must fit in one WORD_W word");
   end
   if ((WORD_W != 8) && (WORD_W != 16) && (WORD_W != 32) && (WORD_W != 64)) begin : g_chk_word
      $error("shake_block_loader: WORD_W must be 8, 16, 32 or 64");
   end
   if (MAX_RATE_BYTES < RATE128_BYTES) begin : g_chk_rate
      $error("shake_block_loader: MAX_RATE_BYTES must hold a SHAKE128 block");
   end

   state_t                      state_q;
   mode_t                       mode_q;
   logic [LEN_W-1:0]            rem_q;
   logic [WIDX_W-1:0]           widx_q;
   logic                        pad_pending_q;
   logic [POS_W-1:0]            pad_pos_q;
   logic [MAX_RATE_BYTES*8-1:0] block_q;
   logic                        blk_valid_q;
   logic                        blk_last_q;

   logic [WIDX_W-1:0]           rate_words;
   logic [POS_W-1:0]            last_pos;
   logic [TK_W-1:0]             taken_d;
   logic [LEN_W-1:0]            rem_d;
   logic [WIDX_W-1:0]           widx_d;
   logic                        partial_d;
   logic [POS_W-1:0]            boundary_pos_d;
   logic [MAX_RATE_BYTES*8-1:0] pad_blk_d;
   logic [WORD_W-1:0]           masked_word;

   shake_word_mask #(
      .WORD_W (WORD_W),
      .TK_W   (TK_W)
   ) u_mask (
      .word_i  (in_data),
      .taken_i (taken_d),
      .pad_i   (partial_d),
      .word_o  (masked_word)
   );

   // Rate geometry, per-word bookkeeping and the padded version of the current block
   always_comb begin
      if (mode_q == SHAKE256) begin
         rate_words = WIDX_W'(RATE256_BYTES / BPW);
         last_pos   = POS_W'(RATE256_BYTES - 1);
      end else begin
         rate_words = WIDX_W'(RATE128_BYTES / BPW);
         last_pos   = POS_W'(RATE128_BYTES - 1);
      end

      if (rem_q < LEN_W'(BPW)) begin
         taken_d = TK_W'(rem_q);
      end else begin
         taken_d = TK_W'(BPW);
      end
      rem_d     = rem_q - LEN_W'(taken_d);
      widx_d    = widx_q + WIDX_W'(1);
      partial_d = (rem_d == '0) && (taken_d != TK_W'(BPW));

      // A message filling the block exactly defers its domain byte to the next block
      if (widx_d == rate_words) begin
         boundary_pos_d = '0;
      end else begin
         boundary_pos_d = POS_W'(int'(widx_d) * BPW);
      end

      pad_blk_d = block_q;
      if (pad_pending_q) begin
         pad_blk_d[int'(pad_pos_q)*8 +: 8] = block_q[int'(pad_pos_q)*8 +: 8] | DOMAIN_PAD;
      end else begin
         pad_blk_d = block_q;
      end
      pad_blk_d[int'(last_pos)*8 +: 8] = pad_blk_d[int'(last_pos)*8 +: 8] | FINAL_PAD;
   end

   assign in_ready = !rst && ((state_q == IDLE) ||
                              ((state_q == LOAD) && (rem_q != '0) && (widx_q < rate_words)));

   // Loader FSM with block register and registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         mode_q        <= SHAKE128;
         rem_q         <= '0;
         widx_q        <= '0;
         pad_pending_q <= 1'b0;
         pad_pos_q     <= '0;
         block_q       <= '0;
         blk_valid_q   <= 1'b0;
         blk_last_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  rem_q     <= in_data[LEN_W-1:0];
                  mode_q    <= mode_t'(in_data[LEN_W]);
                  widx_q    <= '0;
                  block_q   <= '0;
                  pad_pos_q <= '0;
                  if (in_data[LEN_W-1:0] == '0) begin
                     pad_pending_q <= 1'b1;
                     state_q       <= PAD;
                  end else begin
                     pad_pending_q <= 1'b0;
                     state_q       <= LOAD;
                  end
               end
            end
            LOAD: begin
               if (in_valid && in_ready) begin
                  block_q[int'(widx_q)*WORD_W +: WORD_W] <= masked_word;
                  rem_q  <= rem_d;
                  widx_q <= widx_d;
                  if ((rem_d == '0) && !partial_d) begin
                     pad_pending_q <= 1'b1;
                     pad_pos_q     <= boundary_pos_d;
                  end
                  // A partial last word always needs the PAD cycle for its final byte
                  if (partial_d) begin
                     state_q <= PAD;
                  end else if (widx_d == rate_words) begin
                     state_q     <= HOLD;
                     blk_valid_q <= 1'b1;
                     blk_last_q  <= 1'b0;
                  end else if (rem_d == '0) begin
                     state_q <= PAD;
                  end
               end
            end
            PAD: begin
               block_q       <= pad_blk_d;
               pad_pending_q <= 1'b0;
               state_q       <= HOLD;
               blk_valid_q   <= 1'b1;
               blk_last_q    <= 1'b1;
            end
            HOLD: begin
               if (blk_ready) begin
                  blk_valid_q <= 1'b0;
                  blk_last_q  <= 1'b0;
                  if (blk_last_q) begin
                     state_q <= IDLE;
                  end else if (rem_q != '0) begin
                     state_q <= LOAD;
                     widx_q  <= '0;
                     block_q <= '0;
                  end else begin
                     state_q <= PAD;
                     block_q <= '0;
                  end
               end
            end
            default: begin
               state_q     <= IDLE;
               blk_valid_q <= 1'b0;
               blk_last_q  <= 1'b0;
            end
         endcase
      end
   end

   assign blk_valid = blk_valid_q;
   assign blk_last  = blk_last_q;
   assign blk_mode  = mode_q;
   assign blk_data  = block_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shake_block_loader.sv
// Self-checking bench for shake_block_loader: a table of messages with random payloads
// checked against a byte-level SHAKE padding model, plus hand-written corner sequences.
module tb_shake_block_loader;
   import shake_pkg::*;

   localparam int WORD_W = 64;
   localparam int LEN_W  = 32;
   localparam int MRB    = 168;
   localparam int BPW    = WORD_W / 8;

   typedef logic [MRB*8-1:0] blk_t;

   typedef struct {
      bit         m;
      int         len;
      int         nblk;
      int         pidx;
      logic [7:0] pval;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_data;
   logic              blk_valid;
   logic              blk_ready;
   blk_t              blk_data;
   logic              blk_last;
   logic              blk_mode;
   logic              busy;

   int   n_checks = 0;
   int   n_fail   = 0;
   blk_t exp_blk[$];
   bit   exp_last[$];
   blk_t last_seen;

   always #5 clk = ~clk;

   shake_block_loader #(
      .WORD_W         (WORD_W),
      .LEN_W          (LEN_W),
      .MAX_RATE_BYTES (MRB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .blk_last  (blk_last),
      .blk_mode  (blk_mode),
      .busy      (busy)
   );

   task automatic check_int(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_blk(input string name, input blk_t act, input blk_t exp);
      int bad;
      bad = -1;
      n_checks++;
      for (int i = MRB - 1; i >= 0; i--) begin
         if (act[8*i +: 8] !== exp[8*i +: 8]) bad = i;
      end
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL %s: byte %0d got %02h expected %02h", name, bad,
                  act[8*bad +: 8], exp[8*bad +: 8]);
      end
   endtask

   function automatic logic [WORD_W-1:0] hdr(input bit m, input int len);
      return (WORD_W'(m) << LEN_W) | WORD_W'(len);
   endfunction

   function automatic blk_t pad_only(input int rate);
      blk_t v;
      v = '0;
      v[7:0] = 8'h1F;
      v[(rate-1)*8 +: 8] = 8'h80;
      return v;
   endfunction

   // Reference: append the domain byte, extend to a whole number of rate blocks,
   // set the top bit of the very last byte, then cut into blocks.
   task automatic model(input bit m, input int len, input logic [7:0] msg[$]);
      bit [7:0] p[];
      int       rate;
      int       plen;
      int       nb;
      blk_t     v;
      rate = m ? 136 : 168;
      plen = ((len + rate) / rate) * rate;
      p = new[plen];
      for (int i = 0; i < len; i++) p[i] = msg[i];
      p[len]      = p[len] | 8'h1F;
      p[plen - 1] = p[plen - 1] | 8'h80;
      nb = plen / rate;
      exp_blk  = {};
      exp_last = {};
      for (int b = 0; b < nb; b++) begin
         v = '0;
         for (int i = 0; i < rate; i++) v[8*i +: 8] = p[b*rate + i];
         exp_blk.push_back(v);
         exp_last.push_back(b == nb - 1);
      end
   endtask

   // Streams one random message with random valid/ready gaps and scores every block
   task automatic run_msg(input bit m, input int len, input int nblk, input int ready_pct);
      logic [7:0]        msg[$];
      logic [WORD_W-1:0] wq[$];
      logic [WORD_W-1:0] d;
      int nw, wi, blk, cyc, extra, hold_rdy;
      msg = {};
      wq  = {};
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      nw = (len + BPW - 1) / BPW;
      wq.push_back(hdr(m, len));
      for (int w = 0; w < nw; w++) begin
         for (int j = 0; j < BPW; j++) begin
            if (w*BPW + j < len) d[8*j +: 8] = msg[w*BPW + j];
            else                 d[8*j +: 8] = 8'($urandom);
         end
         wq.push_back(d);
      end
      model(m, len, msg);
      wi = 0; blk = 0; cyc = 0; extra = 0; hold_rdy = 0;
      while (blk < exp_blk.size() && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         in_valid  = (wi < wq.size()) && ($urandom_range(99) < 80);
         in_data   = (wi < wq.size()) ? wq[wi] : WORD_W'({$urandom, $urandom});
         blk_ready = ($urandom_range(99) < ready_pct);
         #1;
         if (in_ready && wi >= wq.size()) extra++;
         if (in_ready && blk_valid) hold_rdy++;
         if (in_valid && in_ready) wi++;
         if (blk_valid && blk_ready) begin
            check_blk($sformatf("blk m%0d len%0d #%0d data", m, len, blk), blk_data, exp_blk[blk]);
            check_int($sformatf("blk m%0d len%0d #%0d last", m, len, blk), blk_last, exp_last[blk]);
            check_int($sformatf("blk m%0d len%0d #%0d mode", m, len, blk), blk_mode, m);
            last_seen = blk_data;
            blk++;
         end
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      blk_ready = 1'b0;
      check_int($sformatf("m%0d len%0d block count", m, len), blk, nblk);
      check_int($sformatf("m%0d len%0d words accepted", m, len), wi, wq.size());
      check_int($sformatf("m%0d len%0d extra in_ready", m, len), extra, 0);
      check_int($sformatf("m%0d len%0d in_ready in HOLD", m, len), hold_rdy, 0);
   endtask

   task automatic send_word(input logic [WORD_W-1:0] d, input string name);
      int c;
      c = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      #1;
      while (!in_ready && c < 100) begin
         @(negedge clk);
         #1;
         c++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (c >= 100) check_int({name, " accept timeout"}, c, 0);
   endtask

   // Cycles from the accept cycle until blk_valid, counting the accept cycle as 0
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!blk_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic take_blk();
      @(negedge clk);
      blk_ready = 1'b1;
      @(posedge clk);
      #1;
      blk_ready = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[11];
      blk_t snap;
      blk_t expv;
      int   lat, acc, rm, rl, rr;

      rst = 1'b1; in_valid = 1'b0; in_data = '0; blk_ready = 1'b0;
      tbl[0]  = '{1'b0,   0, 1,   0, 8'h1F};
      tbl[1]  = '{1'b1,   5, 1, 135, 8'h80};
      tbl[2]  = '{1'b0, 168, 2,   0, 8'h1F};
      tbl[3]  = '{1'b1, 135, 1, 135, 8'h9F};
      tbl[4]  = '{1'b1, 136, 2, 135, 8'h80};
      tbl[5]  = '{1'b0, 167, 1, 167, 8'h9F};
      tbl[6]  = '{1'b0, 160, 1, 160, 8'h1F};
      tbl[7]  = '{1'b1, 272, 3,   0, 8'h1F};
      tbl[8]  = '{1'b0, 169, 2,   1, 8'h1F};
      tbl[9]  = '{1'b1,  13, 1,  13, 8'h1F};
      tbl[10] = '{1'b0, 336, 3, 167, 8'h80};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_int("reset in_ready", in_ready, 0);
      check_int("reset busy", busy, 0);
      check_int("reset blk_valid", blk_valid, 0);
      check_int("reset blk_last", blk_last, 0);
      check_int("reset blk_mode", blk_mode, 0);
      check_blk("reset blk_data", blk_data, '0);
      rst = 1'b0;
      #1;
      check_int("idle in_ready", in_ready, 1);

      // SHAKE128 empty message
      send_word(hdr(1'b0, 0), "len0 hdr");
      wait_valid(lat);
      check_int("len0 latency", lat, 2);
      check_blk("len0 data", blk_data, pad_only(168));
      check_int("len0 last", blk_last, 1);
      check_int("len0 mode", blk_mode, 0);
      take_blk();
      check_int("len0 idle in_ready", in_ready, 1);

      // SHAKE256, 5 bytes, garbage in the untaken upper bytes, then backpressure
      send_word(hdr(1'b1, 5), "len5 hdr");
      send_word(64'hDEADBE1122334455, "len5 word");
      wait_valid(lat);
      check_int("len5 latency", lat, 2);
      expv = '0;
      expv[39:0]        = 40'h1122334455;
      expv[47:40]       = 8'h1F;
      expv[135*8 +: 8]  = 8'h80;
      check_blk("len5 data", blk_data, expv);
      check_int("len5 last", blk_last, 1);
      check_int("len5 mode", blk_mode, 1);
      snap = blk_data;
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid  = 1'b1;
         in_data   = WORD_W'({$urandom, $urandom});
         blk_ready = 1'b0;
         #1;
         if (in_valid && in_ready) acc++;
         check_blk($sformatf("bp data cyc%0d", i), blk_data, snap);
         check_int($sformatf("bp valid cyc%0d", i), blk_valid, 1);
         check_int($sformatf("bp last cyc%0d", i), blk_last, 1);
      end
      in_valid = 1'b0;
      check_int("bp accepted words", acc, 0);
      take_blk();
      check_int("after handshake busy", busy, 0);
      check_int("after handshake in_ready", in_ready, 1);

      // SHAKE256 exact block: non-final latency, then padding-only block
      send_word(hdr(1'b1, 136), "len136 hdr");
      for (int w = 0; w < 17; w++) send_word(WORD_W'({$urandom, $urandom}), "len136 word");
      wait_valid(lat);
      check_int("len136 non-final latency", lat, 1);
      check_int("len136 first last", blk_last, 0);
      take_blk();
      check_int("len136 no in_ready after boundary", in_ready, 0);
      wait_valid(lat);
      check_blk("len136 pad block", blk_data, pad_only(136));
      check_int("len136 pad last", blk_last, 1);
      take_blk();

      // Reset mid-message
      send_word(hdr(1'b0, 40), "rst hdr");
      for (int w = 0; w < 3; w++) send_word(WORD_W'({$urandom, $urandom}), "rst word");
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_int("rst in_ready while high", in_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_int("post-rst busy", busy, 0);
      check_int("post-rst blk_valid", blk_valid, 0);
      check_int("post-rst in_ready", in_ready, 1);
      check_blk("post-rst blk_data", blk_data, '0);
      send_word(hdr(1'b0, 0), "post-rst hdr");
      wait_valid(lat);
      check_int("post-rst latency", lat, 2);
      check_blk("post-rst pad block", blk_data, pad_only(168));
      check_int("post-rst last", blk_last, 1);
      take_blk();

      // Table-driven messages with random payloads
      for (int t = 0; t < 11; t++) begin
         run_msg(tbl[t].m, tbl[t].len, tbl[t].nblk, 60);
         check_int($sformatf("tbl%0d probe byte %0d", t, tbl[t].pidx),
                   last_seen[tbl[t].pidx*8 +: 8], tbl[t].pval);
      end

      // Fully random messages
      for (int r = 0; r < 6; r++) begin
         rm = $urandom_range(1);
         rl = $urandom_range(400);
         rr = rm ? 136 : 168;
         run_msg(rm[0], rl, rl / rr + 1, 40 + 10 * r);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/shake_block_loader.md
Name: shake_block_loader

Overview:
- Parametrised successor of the SHAKE input-load controller.
- Accepts a header word, then a byte-length-bounded stream of message words.
- Packs the words into rate-sized blocks for SHAKE128 or SHAKE256, applies Keccak padding (0x1F … 0x80) internally, and hands each completed block to the absorb stage through a valid/ready handshake.
- Sits between the top-level input port and the permutation/absorb pipeline stage.

Parameters:
- WORD_W, 64, input word width in bits; one of 8/16/32/64 (so 136 and 168 bytes are whole words).
- LEN_W, 32, width of the message byte-length field; requires WORD_W ≥ LEN_W+1 (header fits one word) — elaboration assertion.
- MAX_RATE_BYTES, 168, block register size in bytes (SHAKE128 rate).

Ports:
- clk  in  1  clock; single clock domain, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid & in_ready.
- in_data  in  WORD_W  header or message word; byte 0 = bits[7:0].
- blk_valid  out  1  block register holds a complete block.
- blk_ready  in  1  absorb stage consumes block.
- blk_data  out  MAX_RATE_BYTES*8  block, byte i = bits[8i+7:8i].
- blk_last  out  1  block is the final (padded) block of the message.
- blk_mode  out  1  0 = SHAKE128 (rate 168), 1 = SHAKE256 (rate 136).
- busy  out  1  state ≠ IDLE.

Behaviour:
- Reset:
  - rst high at a clock edge → state IDLE; block register, counters, pad_pending and mode cleared.
  - blk_valid = blk_last = blk_mode = busy = 0.
  - in_ready = 0 whenever rst = 1; same behaviour when rst is asserted mid-operation (no partial block emitted).
- Header (IDLE): in_ready = 1.
  - On accept: len ← in_data[LEN_W-1:0], mode ← in_data[LEN_W]; rate_words = rate_bytes/(WORD_W/8); widx ← 0; block register ← 0.
  - len = 0 → PAD with pad_pending = 1 at byte 0.
  - len > 0 → LOAD.
- LOAD: in_ready = 1 iff rem > 0 and widx < rate_words. Each accepted word:
  - taken = min(rem, WORD_W/8); bytes ≥ taken are masked to 0.
  - Word is stored at word slot widx; rem -= taken; widx++.
  - If rem becomes 0 and taken < WORD_W/8: 0x1F is written into byte `taken` of that same word.
  - If rem becomes 0 and taken = WORD_W/8: pad_pending ← 1 at byte position widx_next*WORD_W/8.
- LOAD exits, evaluated after the accept:
  - widx reaches rate_words → HOLD, blk_last = 0.
  - rem = 0 with block space left → PAD.
- PAD (exactly one cycle):
  - If pad_pending, OR 0x1F at the pad position, then clear pad_pending.
  - OR 0x80 into byte rate_bytes-1; pos = rate_bytes-1 therefore yields 0x9F.
  - → HOLD with blk_last = 1.
- Message ending exactly on a block boundary: HOLD with blk_last = 0 and pad_pending = 1 at byte 0. The next block is padding only.
- HOLD: blk_valid = 1; blk_data, blk_last and blk_mode are stable until handshake; in_ready = 0. On blk_valid & blk_ready:
  - blk_last → IDLE.
  - else rem > 0 → LOAD, widx ← 0, block register ← 0.
  - else (pad_pending) → PAD, block register ← 0.
- Bytes at index ≥ rate_bytes (SHAKE256) are always 0.
- Latency:
  - Non-final block: blk_valid is asserted the cycle after the rate_words-th accept.
  - Final block: blk_valid is asserted 2 cycles after the last accept (LOAD→PAD→HOLD).
  - Earliest in_ready after block handshake: next cycle.
- Counters: rem is LEN_W bits wide and cannot underflow (taken ≤ rem); widx is $clog2(MAX_RATE_BYTES/(WORD_W/8))+1 bits wide.
- in_valid while in_ready = 0: ignored, no state change.

Decomposition:
- Shared package shake_pkg:
  - mode_t enum {SHAKE128, SHAKE256}.
  - RATE128_BYTES = 168, RATE256_BYTES = 136.
  - DOMAIN_PAD = 8'h1F, FINAL_PAD = 8'h80.
  - loader state_t {IDLE, LOAD, PAD, HOLD}.
- One combinational sub-module, shake_word_mask: takes word, taken count and pad flag; returns the masked word with the 0x1F byte inserted.

Test Plan (WORD_W = 64):
- SHAKE128, len = 0 → single block, byte0 = 0x1F, byte167 = 0x80, all others 0, blk_last = 1, blk_mode = 0.
- SHAKE256, len = 5, word 0x000000_1122334455 → bytes0–4 = 55 44 33 22 11, byte5 = 0x1F, byte135 = 0x80, bytes136–167 = 0, blk_last = 1.
- SHAKE128, len = 168, 21 words → block 1 with blk_last = 0 and data intact; then a block with byte0 = 0x1F, byte167 = 0x80, blk_last = 1, and no extra in_ready.
- SHAKE256, len = 135, 17 words (last word 7 valid bytes) → byte135 = 0x9F, final word byte7 not taken from in_data.
- Backpressure: blk_ready low for 10 cycles in HOLD → blk_data/blk_last stable, in_ready = 0, accepted in_valid words = 0.
- rst pulsed after 3 message words → next cycle busy = 0, blk_valid = 0, in_ready = 1; new header len = 0 produces the correct padding-only block.
